// File: rtl/fp_add_seq.sv
// Multi-cycle floating-point adder S = A + B behind valid/ready handshakes.
// Operands are aligned, added as magnitudes, then normalized one bit per
// cycle. Rounding is truncation and denormal operands are flushed to zero.
module fp_add_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   add_a,
  input  logic [EXP_W+MAN_W:0]   add_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   add_s,
  output logic                   out_ovf,
  output logic                   out_zero
);

  localparam logic [EXP_W-1:0]       EXP_ONES  = '1;
  localparam logic [EXP_W-1:0]       EXP_ONE   = EXP_W'(1);
  localparam logic [EXP_W-1:0]       MAX_SHIFT = EXP_W'(MAN_W + 1);
  localparam logic [EXP_W+MAN_W:0]   QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} stateT;

  stateT state, stateNext;

  // Latched operands and working datapath
  logic [EXP_W+MAN_W:0] aReg, bReg;
  logic [MAN_W+1:0]     manA, manB, manS;
  logic [EXP_W-1:0]     expS;
  logic                 signA, signB, signS;
  logic                 special, specZero;
  logic [EXP_W+MAN_W:0] specRes;

  // Alignment helpers derived from the latched operands
  logic [EXP_W-1:0]     expA, expB, expDiff, expBig;
  logic [MAN_W+1:0]     fullA, fullB, alignA, alignB;
  logic                 anyNan, aZero, bZero;

  // Normalization helpers
  logic [EXP_W-1:0]     expInc;
  logic [MAN_W+1:0]     manHalf;

  // Unpack both operands, shift the smaller-exponent mantissa into alignment
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    expA    = aReg[EXP_W+MAN_W-1:MAN_W];
    expB    = bReg[EXP_W+MAN_W-1:MAN_W];
    fullA   = {2'b01, aReg[MAN_W-1:0]};
    fullB   = {2'b01, bReg[MAN_W-1:0]};
    alignA  = fullA;
    alignB  = fullB;
    expDiff = '0;
    expBig  = expA;
    if (expA >= expB) begin
      expDiff = expA - expB;
      expBig  = expA;
      alignB  = (expDiff > MAX_SHIFT) ? '0 : (fullB >> expDiff);
    end else begin
      expDiff = expB - expA;
      expBig  = expB;
      alignA  = (expDiff > MAX_SHIFT) ? '0 : (fullA >> expDiff);
    end
    anyNan  = (expA == EXP_ONES) || (expB == EXP_ONES);
    aZero   = (expA == '0);
    bZero   = (expB == '0);
    expInc  = expS + EXP_ONE;
    manHalf = manS >> 1;
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) stateNext = ALIGN;
      end
      ALIGN: stateNext = ADD;
      ADD:   stateNext = NORM;
      NORM: begin
        if (special || manS[MAN_W+1] || (manS == '0) || manS[MAN_W] || (expS == EXP_ONE))
          stateNext = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: latch, align, add magnitudes, normalize and form the result
  always_ff @(posedge clk) begin
    // NOTE: only the visible outputs are reset; working registers are always written before they are read.
    if (rst) begin
      add_s    <= '0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            aReg     <= add_a;
            bReg     <= add_b;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
          end
        end
        ALIGN: begin
          manA     <= alignA;
          manB     <= alignB;
          expS     <= expBig;
          signA    <= aReg[EXP_W+MAN_W];
          signB    <= bReg[EXP_W+MAN_W];
          special  <= anyNan || aZero || bZero;
          specZero <= !anyNan && aZero && bZero;
          if (anyNan)             specRes <= QNAN;
          else if (aZero && bZero) specRes <= '0;
          else if (aZero)          specRes <= bReg;
          else                     specRes <= aReg;
        end
        ADD: begin
          if (signA == signB) begin
            manS  <= manA + manB;
            signS <= signA;
          end else if (manA >= manB) begin
            manS  <= manA - manB;
            signS <= signA;
          end else begin
            manS  <= manB - manA;
            signS <= signB;
          end
        end
        NORM: begin
          if (special) begin
            add_s    <= specRes;
            out_zero <= specZero;
          end else if (manS[MAN_W+1]) begin
            if (expInc == EXP_ONES) begin
              add_s   <= {signS, EXP_ONES, {MAN_W{1'b0}}};
              out_ovf <= 1'b1;
            end else begin
              add_s <= {signS, expInc, manHalf[MAN_W-1:0]};
            end
          end else if (manS == '0) begin
            add_s    <= '0;
            out_zero <= 1'b1;
          end else if (manS[MAN_W]) begin
            add_s <= {signS, expS, manS[MAN_W-1:0]};
          end else begin
            manS <= manS << 1;
            expS <= expS - EXP_ONE;
            if (expS == EXP_ONE) begin
              add_s    <= '0;
              out_zero <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// Self-checking bench for fp_add_seq: directed cases, backpressure, reset
// abort and randomized operands scored against an integer reference model.
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] add_a, add_b, add_s;
  logic        out_valid, out_ready, out_ovf, out_zero;

  fp_add_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .add_s(add_s), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic        ovf;
    logic        zero;
    int          lat;
    int          acc;
  } expT;

  expT sb[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  readyMode = 0;   // 0: always ready, 1: random, 2: stalled
  bit  seen = 0;
  bit  expectIdle = 0;

  always @(posedge clk) cyc++;

  // Consumer side: out_ready changes just after the edge
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: exact integer sum of aligned (truncated) mantissas,
  // then leading-one normalization with the exponent limits applied.
  function automatic expT model(input logic [31:0] a, input logic [31:0] b);
    expT    r;
    int     ea, eb, e, diff, shift;
    longint ma, mb, sum, mag;
    bit     sgn;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    r.ovf = 0; r.zero = 0; r.lat = 3; r.acc = 0;
    if (ea == 255 || eb == 255) begin r.s = 32'h7FC00000; return r; end
    if (ea == 0 && eb == 0) begin r.s = 0; r.zero = 1; return r; end
    if (ea == 0) begin r.s = b; return r; end
    if (eb == 0) begin r.s = a; return r; end
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    e = (ea > eb) ? ea : eb;
    diff = (ea > eb) ? ea - eb : eb - ea;
    if (ea > eb) mb = (diff > 24) ? 0 : (mb >> diff);
    else         ma = (diff > 24) ? 0 : (ma >> diff);
    sum = (a[31] ? -ma : ma) + (b[31] ? -mb : mb);
    sgn = (sum < 0);
    mag = sgn ? -sum : sum;
    if (mag == 0) begin r.s = 0; r.zero = 1; return r; end
    if (mag >= (64'd1 << 24)) begin
      e = e + 1;
      if (e == 255) begin r.s = {sgn, 8'hFF, 23'd0}; r.ovf = 1; end
      else begin
        mag = mag >> 1;
        r.s = {sgn, 8'(e), mag[22:0]};
      end
      return r;
    end
    shift = 0;
    while (mag < (64'd1 << 23)) begin mag = mag << 1; shift++; end
    if (shift >= e) begin r.s = 0; r.zero = 1; r.lat = 2 + e; return r; end
    r.s = {sgn, 8'(e - shift), mag[22:0]};
    r.lat = 3 + shift;
    return r;
  endfunction

  // Monitor: compares every presented result against the scoreboard head
  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
      expectIdle = 0;
    end else begin
      if (expectIdle) begin
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        expectIdle = 0;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result actual=%h required=none", add_s);
        end else begin
          if (!seen) begin
            seen = 1;
            check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          end
          check("add_s", add_s, sb[0].s);
          check("out_ovf", {31'd0, out_ovf}, {31'd0, sb[0].ovf});
          check("out_zero", {31'd0, out_zero}, {31'd0, sb[0].zero});
          check("busy_in_ready", {31'd0, in_ready}, 32'd0);
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 0;
            expectIdle = 1;
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
    expT e;
    int  t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    add_a = a;
    add_b = b;
    in_valid = 1'b1;
    e = model(a, b);
    e.acc = cyc + 1;
    if (push) sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  function automatic int clampExp(input int e);
    return (e < 1) ? 1 : ((e > 254) ? 254 : e);
  endfunction

  initial begin
    logic [31:0] a, b;
    int          ea, eb, mode, t;

    rst = 1'b1; in_valid = 1'b0; add_a = '0; add_b = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_add_s", add_s, 32'd0);
    check("rst_ovf", {31'd0, out_ovf}, 32'd0);
    check("rst_zero", {31'd0, out_zero}, 32'd0);
    rst = 1'b0;

    // Directed cases
    issue(32'h3F800000, 32'h3F800000, 1);
    issue(32'h3F800000, 32'hBF800000, 1);
    issue(32'h3FC00000, 32'hBF800000, 1);
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1);
    issue(32'h3F800000, 32'h30800000, 1);
    issue(32'h7F800000, 32'h12345678, 1);
    issue(32'h00000000, 32'h80000000, 1);
    issue(32'h00400000, 32'hC0490FDB, 1);
    issue(32'h3F800001, 32'hBF800000, 1);
    issue(32'h00800001, 32'h80800000, 1);
    drain();

    // Backpressure: hold the result for several cycles before accepting
    readyMode = 2;
    issue(32'h3FC00000, 32'h3F800000, 1);
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    check("bp_valid_seen", {31'd0, out_valid}, 32'd1);
    repeat (5) @(negedge clk);
    readyMode = 0;
    drain();

    // Reset during normalization aborts the operation
    issue(32'h3F800001, 32'hBF800000, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_add_s", add_s, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Randomized operands with random backpressure
    readyMode = 1;
    repeat (200) begin
      mode = $urandom_range(0, 9);
      ea = $urandom_range(1, 254);
      eb = clampExp(ea + $urandom_range(0, 6) - 3);
      case (mode)
        2: begin ea = $urandom_range(252, 254); eb = 254; end
        4: begin ea = $urandom_range(1, 20); eb = clampExp(ea + $urandom_range(0, 2) - 1); end
        5: eb = $urandom_range(1, 254);
        default: ;
      endcase
      a = {1'($urandom), 8'(ea), 23'($urandom)};
      b = {1'($urandom), 8'(eb), 23'($urandom)};
      case (mode)
        0: a[30:23] = 8'hFF;
        1: b[30:23] = 8'h00;
        2: b[31] = a[31];
        3: b = {~a[31], a[30:3], 3'($urandom)};
        4: b[31] = ~a[31];
        6: begin a[30:23] = 8'h00; b[30:23] = 8'h00; end
        default: ;
      endcase
      issue(a, b, 1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
